// File: rtl/ritc_bus_pkg.sv
// Shared widths, FSM state encoding and command record for the user register-bus master.
package ritc_bus_pkg;

  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned DAT_W    = 32;
  localparam int unsigned RD_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_RESP    = 2'd3
  } bus_state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DAT_W-1:0]  dat;
  } bus_cmd_t;

endpackage

// File: rtl/ritc_cmd_fifo.sv
// First-word-fall-through command buffer; head_o is valid whenever empty_o is low.
module ritc_cmd_fifo
  import ritc_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  bus_cmd_t push_cmd_i,
  input  logic     pop_i,
  output bus_cmd_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  bus_cmd_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    do_push  = push_i && !full_q;
    do_pop   = pop_i && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_cmd_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/ritc_user_bus_master.sv
// Buffers user commands and replays them one at a time on the datapath register bus,
// returning one response per command in acceptance order.
module ritc_user_bus_master
  import ritc_bus_pkg::*;
#(
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned CMD_FIFO_DEPTH = 4
) (
  input  logic              user_clk_i,
  input  logic              user_rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_wr_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DAT_W-1:0]  cmd_dat_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_wr_o,
  output logic [DAT_W-1:0]  rsp_dat_o,
  output logic              user_sel_o,
  output logic [ADDR_W-1:0] user_addr_o,
  output logic              user_wr_o,
  output logic              user_rd_o,
  output logic [DAT_W-1:0]  user_dat_o,
  input  logic [DAT_W-1:0]  user_dat_i,
  output logic              busy_o
);

  bus_state_e          state_q, state_d;
  logic [RD_CNT_W-1:0] cnt_q, cnt_d;
  logic                user_sel_q, user_sel_d;
  logic                user_wr_q, user_wr_d;
  logic                user_rd_q, user_rd_d;
  logic [ADDR_W-1:0]   user_addr_q, user_addr_d;
  logic [DAT_W-1:0]    user_dat_q, user_dat_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_wr_q, rsp_wr_d;
  logic [DAT_W-1:0]    rsp_dat_q, rsp_dat_d;

  bus_cmd_t            push_cmd;
  bus_cmd_t            head;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;

  assign push_cmd = '{wr: cmd_wr_i, addr: cmd_addr_i, dat: cmd_dat_i};

  ritc_cmd_fifo #(
    .DEPTH (CMD_FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk        (user_clk_i),
    .rst        (user_rst_i),
    .push_i     (cmd_valid_i),
    .push_cmd_i (push_cmd),
    .pop_i      (fifo_pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Bus strobes are computed one state ahead so they are registered during ISSUE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    user_sel_d  = 1'b0;
    user_wr_d   = 1'b0;
    user_rd_d   = 1'b0;
    user_addr_d = user_addr_q;
    user_dat_d  = user_dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_wr_d    = rsp_wr_q;
    rsp_dat_d   = rsp_dat_q;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          state_d     = ST_ISSUE;
          user_sel_d  = 1'b1;
          user_wr_d   = head.wr;
          user_rd_d   = !head.wr;
          user_addr_d = head.addr;
          user_dat_d  = head.dat;
        end
      end
      ST_ISSUE: begin
        if (user_wr_q) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_wr_d    = 1'b1;
          rsp_dat_d   = '0;
        end else begin
          state_d = ST_WAIT_RD;
          cnt_d   = RD_CNT_W'(1);
        end
      end
      ST_WAIT_RD: begin
        // cnt_q counts cycles elapsed since the read strobe.
        if (cnt_q == RD_CNT_W'(READ_LATENCY)) begin
          state_d     = ST_RESP;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_wr_d    = 1'b0;
          rsp_dat_d   = user_dat_i;
        end else begin
          cnt_d = cnt_q + RD_CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk_i or posedge user_rst_i) begin
    if (user_rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      user_sel_q  <= 1'b0;
      user_wr_q   <= 1'b0;
      user_rd_q   <= 1'b0;
      user_addr_q <= '0;
      user_dat_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      user_sel_q  <= user_sel_d;
      user_wr_q   <= user_wr_d;
      user_rd_q   <= user_rd_d;
      user_addr_q <= user_addr_d;
      user_dat_q  <= user_dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

  assign cmd_ready_o = !fifo_full;
  assign busy_o      = !fifo_empty || (state_q != ST_IDLE);
  assign user_sel_o  = user_sel_q;
  assign user_wr_o   = user_wr_q;
  assign user_rd_o   = user_rd_q;
  assign user_addr_o = user_addr_q;
  assign user_dat_o  = user_dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_wr_o    = rsp_wr_q;
  assign rsp_dat_o   = rsp_dat_q;

endmodule

// File: tb/tb_ritc_user_bus_master.sv
// Scoreboard bench: commands are applied to a reference register file on acceptance,
// a monitor checks every bus strobe and response for content and exact cycle timing.
module tb_ritc_user_bus_master;
  import ritc_bus_pkg::*;

  localparam int unsigned RL      = 2;
  localparam int unsigned DEPTH   = 4;
  localparam int          MAX_CYC = 40000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_dat = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_wr;
  logic [31:0] rsp_dat;
  logic        user_sel, user_wr, user_rd;
  logic [3:0]  user_addr;
  logic [31:0] user_dat_o;
  logic [31:0] user_dat_i = '0;
  logic        busy;

  always #5 clk = ~clk;

  ritc_user_bus_master #(
    .READ_LATENCY   (RL),
    .CMD_FIFO_DEPTH (DEPTH)
  ) dut (
    .user_clk_i  (clk),
    .user_rst_i  (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_wr_i    (cmd_wr),
    .cmd_addr_i  (cmd_addr),
    .cmd_dat_i   (cmd_dat),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_wr_o    (rsp_wr),
    .rsp_dat_o   (rsp_dat),
    .user_sel_o  (user_sel),
    .user_addr_o (user_addr),
    .user_wr_o   (user_wr),
    .user_rd_o   (user_rd),
    .user_dat_o  (user_dat_o),
    .user_dat_i  (user_dat_i),
    .busy_o      (busy)
  );

  typedef struct { bit wr; bit [3:0] addr; bit [31:0] dat; int acc; } exp_bus_t;
  typedef struct { bit wr; bit [31:0] dat; } exp_rsp_t;

  exp_bus_t  bus_q [$];
  exp_rsp_t  rsp_q [$];
  bit [31:0] ref_mem [16];
  bit [31:0] bus_mem [16];
  int        total = 0;
  int        bad = 0;
  int        cyc = 0;
  bit        rdy_seen = 1'b0;
  int        rdy_mode = 0;   // 0 always ready, 1 random, 2 low 10 cycles per response, 3 never
  int        n_strobe = 0;

  // Monitor-side state
  int        last_hs = 0;
  bit        in_flight = 1'b0;
  bit        in_rsp = 1'b0;
  bit        hs_pending = 1'b0;
  int        exp_rsp_start = 0;
  exp_rsp_t  cur_rsp;
  bit        rd_active = 1'b0;
  int        rd_age = 0;
  bit [3:0]  rd_addr = '0;
  logic [3:0]  last_addr = '0;
  logic [31:0] last_dat = '0;
  int        low_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register-bus model and response checker; acts on the falling edge.
  always @(negedge clk) begin : monitor
    exp_bus_t e;
    int exp_s;
    if (rst) begin
      bus_q.delete();
      rsp_q.delete();
      in_flight  = 1'b0;
      in_rsp     = 1'b0;
      hs_pending = 1'b0;
      rd_active  = 1'b0;
      last_hs    = 0;
      last_addr  = '0;
      last_dat   = '0;
      rsp_ready  = 1'b0;
      user_dat_i = $urandom;
    end else begin
      if (hs_pending) begin
        in_flight  = 1'b0;
        in_rsp     = 1'b0;
        hs_pending = 1'b0;
      end
      user_dat_i = $urandom;
      if (rd_active) begin
        rd_age++;
        if (rd_age == int'(RL)) begin
          user_dat_i = bus_mem[rd_addr];
          rd_active  = 1'b0;
        end
      end
      if (user_sel) begin
        n_strobe++;
        chk(user_wr ^ user_rd, "strobe_onehot", {user_wr, user_rd}, 1);
        chk(!in_flight, "strobe_overlap", in_flight, 0);
        if (bus_q.size() == 0) begin
          chk(1'b0, "unexpected_strobe", user_addr, 0);
        end else begin
          e = bus_q.pop_front();
          exp_s = (e.acc > last_hs) ? e.acc + 1 : last_hs + 1;
          chk(cyc == exp_s, "strobe_time", cyc, exp_s);
          chk(user_wr == e.wr, "strobe_kind", user_wr, e.wr);
          chk(user_addr == e.addr, "strobe_addr", user_addr, e.addr);
          if (e.wr) begin
            chk(user_dat_o == e.dat, "strobe_wdata", user_dat_o, e.dat);
            bus_mem[user_addr] = user_dat_o;
            exp_rsp_start = cyc + 1;
          end else begin
            rd_active = 1'b1;
            rd_age    = 0;
            rd_addr   = user_addr;
            exp_rsp_start = cyc + int'(RL) + 1;
          end
          in_flight = 1'b1;
        end
        last_addr = user_addr;
        last_dat  = user_dat_o;
      end else begin
        chk(!user_wr && !user_rd, "strobe_outside_issue", {user_wr, user_rd}, 0);
        chk(user_addr == last_addr && user_dat_o == last_dat, "bus_hold", user_dat_o, last_dat);
      end
      if (rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1'b1;
          low_cnt = (rdy_mode == 2) ? 10 : 0;
          if (rsp_q.size() == 0) begin
            chk(1'b0, "unexpected_rsp", rsp_dat, 0);
            cur_rsp = '{wr: rsp_wr, dat: rsp_dat};
          end else begin
            cur_rsp = rsp_q.pop_front();
            chk(cyc == exp_rsp_start, "rsp_time", cyc, exp_rsp_start);
          end
        end
        chk(rsp_wr == cur_rsp.wr, "rsp_wr", rsp_wr, cur_rsp.wr);
        chk(rsp_dat == cur_rsp.dat, "rsp_dat", rsp_dat, cur_rsp.dat);
        case (rdy_mode)
          0: rsp_ready = 1'b1;
          1: rsp_ready = 1'($urandom_range(0, 1));
          2: begin
            rsp_ready = (low_cnt == 0);
            if (low_cnt > 0) low_cnt--;
          end
          default: rsp_ready = 1'b0;
        endcase
        if (rsp_ready) begin
          hs_pending = 1'b1;
          last_hs    = cyc + 1;
        end
      end else begin
        chk(!in_rsp, "rsp_dropped", rsp_valid, in_rsp);
        rsp_ready = 1'($urandom_range(0, 1));
      end
      if (bus_q.size() != 0 || in_flight) chk(busy, "busy", busy, 1);
    end
  end

  // One falling edge; records the command accepted on the rising edge just passed.
  task automatic tick(output bit acc);
    @(negedge clk);
    acc = 1'b0;
    if (cmd_valid && rdy_seen && !rst) begin
      acc = 1'b1;
      bus_q.push_back('{wr: cmd_wr, addr: cmd_addr, dat: cmd_dat, acc: cyc});
      if (cmd_wr) begin
        ref_mem[cmd_addr] = cmd_dat;
        rsp_q.push_back('{wr: 1'b1, dat: 32'h0});
      end else begin
        rsp_q.push_back('{wr: 1'b0, dat: ref_mem[cmd_addr]});
      end
    end
    rdy_seen = cmd_ready;
  endtask

  task automatic send(input bit wr, input bit [3:0] a, input bit [31:0] d);
    bit acc;
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_dat   = d;
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 300);
    if (!acc) chk(1'b0, "send_timeout", n, 300);
    cmd_valid = 1'b0;
    cmd_dat   = $urandom;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while ((bus_q.size() != 0 || rsp_q.size() != 0 || in_flight) && n < 600) begin
      tick(acc);
      n++;
    end
    chk(n < 600, "drain_timeout", n, 600);
    tick(acc);
    chk(busy == 1'b0, "idle_busy", busy, 0);
    chk(cmd_ready == 1'b1, "idle_ready", cmd_ready, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(cmd_ready == 1'b1 && busy == 1'b0, {tag, "_ready_busy"}, {cmd_ready, busy}, 2'b10);
    chk(rsp_valid == 1'b0 && rsp_wr == 1'b0 && rsp_dat == '0, {tag, "_rsp"}, rsp_dat, 0);
    chk(user_sel == 1'b0 && user_wr == 1'b0 && user_rd == 1'b0, {tag, "_strobes"},
        {user_sel, user_wr, user_rd}, 0);
    chk(user_addr == '0 && user_dat_o == '0, {tag, "_bus"}, user_dat_o, 0);
  endtask

  initial begin : watchdog
    repeat (MAX_CYC) @(posedge clk);
    $display("FAIL watchdog: cycle budget of %0d exhausted", MAX_CYC);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int s0;
    bit acc;
    #1 rst = 1'b1;
    #1 chk_reset_outputs("reset");
    for (int i = 0; i < 16; i++) begin
      bus_mem[i] = $urandom;
      ref_mem[i] = bus_mem[i];
    end
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    tick(acc);

    // Single write then single read with prompt response consumption.
    rdy_mode = 0;
    send(1'b1, 4'h1, 32'hDEADBEEF);
    drain();
    bus_mem[3] = 32'h0000_1234;
    ref_mem[3] = 32'h0000_1234;
    send(1'b0, 4'h3, $urandom);
    drain();

    // Five back-to-back commands against a stalled response path.
    rdy_mode = 3;
    s0 = n_strobe;
    for (int i = 0; i < 5; i++) send(1'($urandom_range(0, 1)), 4'($urandom), $urandom);
    chk(cmd_ready == 1'b0, "fifo_full", cmd_ready, 0);
    idle(8);
    chk(n_strobe - s0 == 1, "stall_strobes", n_strobe - s0, 1);
    chk(cmd_ready == 1'b0, "fifo_full_held", cmd_ready, 0);
    rdy_mode = 0;
    drain();

    // Long response back-pressure on a read and a write.
    rdy_mode = 2;
    send(1'b0, 4'h1, $urandom);
    send(1'b1, 4'h7, $urandom);
    send(1'b0, 4'h7, $urandom);
    drain();

    // Reset while a read waits for data with two commands queued.
    rdy_mode = 0;
    send(1'b0, 4'h5, $urandom);
    send(1'b1, 4'h6, $urandom);
    send(1'b1, 4'h8, $urandom);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("midreset");
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = bus_mem[i];
    tick(acc);
    chk(rsp_valid == 1'b0, "no_rsp_after_reset", rsp_valid, 0);
    send(1'b1, 4'h2, $urandom);
    drain();

    // Randomised traffic with random response back-pressure.
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      send(1'($urandom_range(0, 1)), 4'($urandom), $urandom);
    end
    rdy_mode = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ritc_user_bus_master.md
RITC_USER_BUS_MASTER -- requirements
Module: ritc_user_bus_master

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 2, cycles from bus read strobe to valid user_dat_i; legal range 1..7.
REQ-002 SHALL have parameter CMD_FIFO_DEPTH, default 4, command buffer entries; power of two, 2..16.
REQ-003 SHALL have port user_clk_i  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port user_rst_i  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid_i  in  1  command offered.
REQ-006 SHALL have port cmd_ready_o  out  1  command buffer can accept.
REQ-007 SHALL have port cmd_wr_i  in  1  1=write, 0=read.
REQ-008 SHALL have port cmd_addr_i  in  4  datapath register address.
REQ-009 SHALL have port cmd_dat_i  in  32  write data; ignored for reads.
REQ-010 SHALL have port rsp_valid_o  out  1  response available.
REQ-011 SHALL have port rsp_ready_i  in  1  response consumed.
REQ-012 SHALL have port rsp_wr_o  out  1  response belongs to a write.
REQ-013 SHALL have port rsp_dat_o  out  32  read data; 0 for writes.
REQ-014 SHALL have port user_sel_o  out  1  register-bus select.
REQ-015 SHALL have port user_addr_o  out  4  register-bus address.
REQ-016 SHALL have port user_wr_o  out  1  register-bus write strobe.
REQ-017 SHALL have port user_rd_o  out  1  register-bus read strobe.
REQ-018 SHALL have port user_dat_o  out  32  register-bus write data.
REQ-019 SHALL have port user_dat_i  in  32  register-bus read data from datapath.
REQ-020 SHALL have port busy_o  out  1  FIFO non-empty or FSM not IDLE.

Function
REQ-021 SHALL accept a command on any edge with cmd_valid_i and cmd_ready_o both high; cmd_ready_o SHALL be low exactly when the FIFO holds CMD_FIFO_DEPTH entries.
REQ-022 SHALL allow push and pop on the same edge when not full; occupancy then unchanged; pointers wrap modulo CMD_FIFO_DEPTH.
REQ-023 SHALL implement FSM states IDLE, ISSUE, WAIT_RD, RESP.
REQ-024 IDLE: when FIFO non-empty, pop head and go ISSUE; else stay.
REQ-025 ISSUE: exactly one cycle with user_sel_o=1, user_addr_o/user_dat_o from the command, and exactly one of user_wr_o/user_rd_o high; write -> RESP, read -> WAIT_RD.
REQ-026 Outside ISSUE, user_sel_o, user_wr_o, user_rd_o SHALL be 0; user_addr_o and user_dat_o SHALL hold their last values.
REQ-027 WAIT_RD: 3-bit counter; user_dat_i sampled into rsp_dat_o on the edge ending cycle S+READ_LATENCY (S = strobe cycle); then RESP.
REQ-028 RESP: rsp_valid_o=1 with stable rsp_wr_o/rsp_dat_o until the edge where rsp_ready_i=1; then IDLE.
REQ-029 Latency with FIFO empty and FSM IDLE: command accepted on edge N -> strobe in cycle N+2; write response from cycle S+1; read response from cycle S+READ_LATENCY+1.
REQ-030 Bus transactions SHALL be strictly in acceptance order, never overlapping; next strobe earliest one cycle after the response handshake (back-to-back throughput: write 3 cycles, read READ_LATENCY+3 cycles, rsp_ready_i held high).
REQ-031 rsp_dat_o SHALL be forced to 0 for write responses.

Reset
REQ-032 On user_rst_i high, asynchronously: FSM IDLE, FIFO empty, counter 0, all outputs 0 except cmd_ready_o=1.
REQ-033 Reset mid-transaction SHALL discard in-flight and queued commands with no response; strobes drop immediately.
REQ-034 After deassertion, first command SHALL follow REQ-029 timing exactly.

Structure
REQ-035 Shared package ritc_bus_pkg SHALL hold ADDR_W=4, DAT_W=32, the FSM state enum, and the command record (wr, addr, dat).
REQ-036 Command buffer SHALL be sub-module ritc_cmd_fifo (synchronous, registered, full/empty flags, first-word-fall-through).

Verification
REQ-037 Write addr 0x1 data 0xDEADBEEF, rsp_ready_i=1 -> one-cycle user_wr_o at N+2 with addr 0x1, data 0xDEADBEEF; rsp_valid_o at N+3, rsp_wr_o=1, rsp_dat_o=0.
REQ-038 Read addr 0x3, READ_LATENCY=2, model returns 0x00001234 -> user_rd_o at S, rsp_dat_o=0x00001234, rsp_valid_o from S+3.
REQ-039 Push 5 commands back-to-back, rsp_ready_i=0, depth 4 -> cmd_ready_o low after 4th accept plus one pop; exactly one strobe issued; no loss on release.
REQ-040 Hold rsp_ready_i low 10 cycles on a read -> rsp_valid_o/rsp_dat_o stable throughout; no further strobes.
REQ-041 Assert user_rst_i during WAIT_RD with 2 commands queued -> no response, busy_o=0, cmd_ready_o=1; next write strobes at N+2.
